// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } mem_state_t;

    localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall/flush decode: memory hold > branch > load-use.
import pipeline_pkg::*;

module hazard_detect (
    input  logic [3:0] rs1_ID,
    input  logic [3:0] rs2_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [3:0] rd_EX,
    input  logic       mem_read_EX,
    input  logic       invalid_EX,
    input  logic       branch_taken_EX,
    input  logic       mem_req_MEMEX,
    input  logic       mem_ready,
    output logic       mem_hold,
    output logic       stall_IF,
    output logic       stall_ID,
    output logic       stall_EX,
    output logic       stall_MEMEX,
    output logic       flush_ID,
    output logic       flush_EX,
    output logic       flush_WB
);

    logic rd_match;
    logic branch;
    logic load_use;

    assign mem_hold = mem_req_MEMEX && !mem_ready;

    assign rd_match = (rd_EX != REG_ZERO) &&
                      ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                       (rs2_used_ID && (rs2_ID == rd_EX)));

    // Make the three cases mutually exclusive so the decoder is one-hot.
    assign branch   = !mem_hold && branch_taken_EX && !invalid_EX;
    assign load_use = !mem_hold && !branch && mem_read_EX &&
                      !invalid_EX && rd_match;

    always_comb begin
        stall_IF    = 1'b0;
        stall_ID    = 1'b0;
        stall_EX    = 1'b0;
        stall_MEMEX = 1'b0;
        flush_ID    = 1'b0;
        flush_EX    = 1'b0;
        flush_WB    = 1'b0;
        unique case (1'b1)
            mem_hold: begin
                stall_IF    = 1'b1;
                stall_ID    = 1'b1;
                stall_EX    = 1'b1;
                stall_MEMEX = 1'b1;
                flush_WB    = 1'b1;
            end
            branch: begin
                flush_ID = 1'b1;
                flush_EX = 1'b1;
            end
            load_use: begin
                stall_IF = 1'b1;
                stall_ID = 1'b1;
                flush_EX = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline controller: hazard decode, memory-wait FSM with timeout,
// and a saturating fetch-stall counter.
import pipeline_pkg::*;

module pipeline_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rs1_ID,
    input  logic [3:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [3:0]  rd_EX,
    input  logic        mem_read_EX,
    input  logic        invalid_EX,
    input  logic        branch_taken_EX,
    input  logic        mem_req_MEMEX,
    input  logic        mem_ready,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        stall_EX,
    output logic        stall_MEMEX,
    output logic        flush_ID,
    output logic        flush_EX,
    output logic        flush_WB,
    output logic        mem_wait,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

    mem_state_t    state;
    mem_state_t    state_next;
    logic [CW-1:0] wait_count;
    logic [CW-1:0] wait_next;
    logic          timeout_set;

    logic mem_hold;
    logic hd_stall_if;
    logic hd_stall_id;
    logic hd_stall_ex;
    logic hd_stall_mem;
    logic hd_flush_id;
    logic hd_flush_ex;
    logic hd_flush_wb;

    hazard_detect u_hazard (
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .rs1_used_ID     (rs1_used_ID),
        .rs2_used_ID     (rs2_used_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .invalid_EX      (invalid_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_req_MEMEX   (mem_req_MEMEX),
        .mem_ready       (mem_ready),
        .mem_hold        (mem_hold),
        .stall_IF        (hd_stall_if),
        .stall_ID        (hd_stall_id),
        .stall_EX        (hd_stall_ex),
        .stall_MEMEX     (hd_stall_mem),
        .flush_ID        (hd_flush_id),
        .flush_EX        (hd_flush_ex),
        .flush_WB        (hd_flush_wb)
    );

    // Stage controls are forced quiet while reset is asserted.
    assign stall_IF    = hd_stall_if  && !rst;
    assign stall_ID    = hd_stall_id  && !rst;
    assign stall_EX    = hd_stall_ex  && !rst;
    assign stall_MEMEX = hd_stall_mem && !rst;
    assign flush_ID    = hd_flush_id  && !rst;
    assign flush_EX    = hd_flush_ex  && !rst;
    assign flush_WB    = hd_flush_wb  && !rst;

    assign mem_wait = (state != ST_RUN);

    always_comb begin
        state_next  = state;
        wait_next   = wait_count;
        timeout_set = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mem_hold) begin
                    state_next = ST_WAIT;
                    wait_next  = '0;
                end
            end
            ST_WAIT: begin
                if (wait_count != WAIT_MAX) begin
                    wait_next = wait_count + 1'b1;
                end
                if (mem_ready || !mem_req_MEMEX) begin
                    state_next = ST_RUN;
                end else if (wait_next == WAIT_MAX) begin
                    state_next  = ST_TIMEOUT;
                    timeout_set = 1'b1;
                end
            end
            ST_TIMEOUT: begin
                if (mem_ready) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_count  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= state_next;
            wait_count <= wait_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_IF && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller (MEM_TIMEOUT=4).
module tb_pipeline_controller;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  rs1_ID;
    logic [3:0]  rs2_ID;
    logic        rs1_used_ID;
    logic        rs2_used_ID;
    logic [3:0]  rd_EX;
    logic        mem_read_EX;
    logic        invalid_EX;
    logic        branch_taken_EX;
    logic        mem_req_MEMEX;
    logic        mem_ready;
    logic        stall_IF;
    logic        stall_ID;
    logic        stall_EX;
    logic        stall_MEMEX;
    logic        flush_ID;
    logic        flush_EX;
    logic        flush_WB;
    logic        mem_wait;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    logic [31:0] sc_exp = 0;

    pipeline_controller #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .rs1_used_ID     (rs1_used_ID),
        .rs2_used_ID     (rs2_used_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .invalid_EX      (invalid_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_req_MEMEX   (mem_req_MEMEX),
        .mem_ready       (mem_ready),
        .stall_IF        (stall_IF),
        .stall_ID        (stall_ID),
        .stall_EX        (stall_EX),
        .stall_MEMEX     (stall_MEMEX),
        .flush_ID        (flush_ID),
        .flush_EX        (flush_EX),
        .flush_WB        (flush_WB),
        .mem_wait        (mem_wait),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view {sIF,sID,sEX,sMEM,fID,fEX,fWB}.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, stall_IF, stall_ID, stall_EX, stall_MEMEX,
                  flush_ID, flush_EX, flush_WB}, {25'd0, exp});
    endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        rd_EX = 0; mem_read_EX = 0; invalid_EX = 0;
        branch_taken_EX = 0; mem_req_MEMEX = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk("rst_mem_wait", {31'd0, mem_wait}, 0);
        chk("rst_timeout", {31'd0, mem_timeout}, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        mem_req_MEMEX = 1;
        #1 chk_ctl("rst_ctl_quiet", 7'b0000000);
        idle();
        rst = 1'b0;
        tick();

        // load x5 in EX, ID reads rs1=5
        mem_read_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
        #1 chk_ctl("loaduse_rs1", 7'b1100010);
        tick(); sc_exp++;
        invalid_EX = 1;
        #1 chk_ctl("loaduse_bubble", 7'b0000000);
        chk("loaduse_count", stall_cycles, sc_exp);
        idle();
        tick();
        chk("loaduse_count_hold", stall_cycles, sc_exp);

        mem_read_EX = 1; rd_EX = 9; rs2_ID = 9; rs2_used_ID = 1;
        #1 chk_ctl("loaduse_rs2", 7'b1100010);
        rs2_used_ID = 0;
        #1 chk_ctl("rs2_unused", 7'b0000000);
        rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
        #1 chk_ctl("x0_no_hazard", 7'b0000000);
        rd_EX = 5; rs1_ID = 5; branch_taken_EX = 1;
        #1 chk_ctl("branch_over_load", 7'b0000110);
        invalid_EX = 1;
        #1 chk_ctl("branch_bubble", 7'b0000000);
        idle();
        tick();

        // memory hold beats branch
        mem_req_MEMEX = 1; branch_taken_EX = 1;
        #1 chk_ctl("hold_over_branch", 7'b1111001);
        chk("hold_run_state", {31'd0, mem_wait}, 0);
        branch_taken_EX = 0;
        tick(); sc_exp++;
        chk("hold_wait1", {31'd0, mem_wait}, 1);
        tick(); sc_exp++;
        tick(); sc_exp++;
        chk("hold_count3", stall_cycles, sc_exp);
        mem_ready = 1;
        #1 chk_ctl("hold_ready_ctl", 7'b0000000);
        chk("hold_ready_wait", {31'd0, mem_wait}, 1);
        tick();
        chk("hold_back_run", {31'd0, mem_wait}, 0);
        chk("hold_count_final", stall_cycles, sc_exp);
        idle();
        tick();

        // WAIT exits when the request is withdrawn
        mem_req_MEMEX = 1;
        tick(); sc_exp++;
        chk("drop_wait", {31'd0, mem_wait}, 1);
        mem_req_MEMEX = 0;
        tick();
        chk("drop_run", {31'd0, mem_wait}, 0);

        // timeout after MEM_TIMEOUT wait cycles
        mem_req_MEMEX = 1;
        for (int i = 1; i <= 4; i++) begin
            tick(); sc_exp++;
        end
        chk("to_not_yet", {31'd0, mem_timeout}, 0);
        tick(); sc_exp++;
        chk("to_set", {31'd0, mem_timeout}, 1);
        chk("to_mem_wait", {31'd0, mem_wait}, 1);
        for (int i = 6; i <= 10; i++) begin
            tick(); sc_exp++;
        end
        mem_ready = 1;
        tick();
        chk("to_ready_run", {31'd0, mem_wait}, 0);
        chk("to_sticky", {31'd0, mem_timeout}, 1);
        chk("to_count", stall_cycles, sc_exp);
        idle();
        tick();

        // reset in the middle of WAIT
        mem_req_MEMEX = 1;
        tick();
        tick();
        chk("rw_in_wait", {31'd0, mem_wait}, 1);
        rst = 1'b1;
        #1 chk_ctl("rw_ctl_quiet", 7'b0000000);
        chk("rw_mem_wait", {31'd0, mem_wait}, 0);
        chk("rw_timeout", {31'd0, mem_timeout}, 0);
        chk("rw_count", stall_cycles, 0);
        tick();
        rst = 1'b0;
        #1 chk_ctl("rw_hold_again", 7'b1111001);
        tick();
        chk("rw_rewait", {31'd0, mem_wait}, 1);
        tick(); tick(); tick();
        chk("rw_no_early_to", {31'd0, mem_timeout}, 0);
        tick();
        chk("rw_fresh_to", {31'd0, mem_timeout}, 1);
        chk("rw_count_after", stall_cycles, 5);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
